// File: rtl/instr_prefetch_queue_pkg.sv
// Shared constants for the instruction prefetch queue: default word geometry
// and the opcode field type carved from the top of each instruction word.
package instr_prefetch_queue_pkg;

  localparam int WORD_SIZE_DEF = 19;
  localparam int OPCODE_W_DEF  = 5;
  localparam int ADDRESS_W_DEF = WORD_SIZE_DEF - OPCODE_W_DEF;

  typedef logic [OPCODE_W_DEF-1:0]  opcode_t;
  typedef logic [ADDRESS_W_DEF-1:0] address_t;

endpackage

// File: rtl/ir_fifo_core.sv
// Storage array plus read/write pointers and occupancy count for the
// prefetch queue. Reset beats flush, and flush beats any push or pop.
module ir_fifo_core #(
  parameter int WIDTH = 19,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_go;
  logic             rd_go;

  // Qualified strobes: a reset or flush cycle swallows any handshake.
  assign wr_go = wr_en && !flush && !rst;
  assign rd_go = rd_en && !flush && !rst;

  // Pointer and count update; power-of-two depth lets pointers wrap naturally.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_go) wr_ptr <= wr_ptr + 1'b1;
      if (rd_go) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_go, rd_go})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage write port.
  always_ff @(posedge clk) begin
    // NOTE: the data array is deliberately not reset; stale words are never
    // visible because the pointers and count are cleared instead.
    if (wr_go) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: a small FIFO between fetch and the control
// unit. The head word is split into opcode and address fields, both forced
// to zero whenever no instruction is available.
module instr_prefetch_queue
  import instr_prefetch_queue_pkg::*;
#(
  parameter int WORD_SIZE = WORD_SIZE_DEF,
  parameter int OPCODE_W  = OPCODE_W_DEF,
  parameter int DEPTH     = 4
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WORD_SIZE-1:0]          in_instr,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [OPCODE_W-1:0]           out_opcode,
  output logic [WORD_SIZE-OPCODE_W-1:0] out_address,
  output logic [$clog2(DEPTH):0]        count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WORD_SIZE-1:0] head;

  // Handshake flags come straight from the registered count, so a pop in
  // the same cycle never lets a full queue accept, and there is no bypass.
  assign in_ready  = (count < DEPTH_C);
  assign out_valid = (count != '0);

  ir_fifo_core #(
    .WIDTH (WORD_SIZE),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_core (
    .clk   (CLK),
    .rst   (RST),
    .flush (flush),
    .wr_en (in_valid && in_ready),
    .wdata (in_instr),
    .rd_en (out_valid && out_ready),
    .rdata (head),
    .count (count)
  );

  // Field split with zeroing while the queue is empty.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    out_opcode  = '0;
    out_address = '0;
    if (out_valid) begin
      out_opcode  = head[WORD_SIZE-1 -: OPCODE_W];
      out_address = head[WORD_SIZE-OPCODE_W-1:0];
    end
  end

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Self-checking bench for instr_prefetch_queue: directed scenarios followed
// by random traffic, all compared against a queue-based reference model.
module tb_instr_prefetch_queue;

  localparam int DEPTH = 4;

  logic        CLK = 1'b0;
  logic        RST;
  logic        flush;
  logic        in_valid;
  logic [18:0] in_instr;
  logic        out_ready;
  logic        in_ready;
  logic        out_valid;
  logic [4:0]  out_opcode;
  logic [13:0] out_address;
  logic [2:0]  count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [18:0] model_q[$];
  logic [18:0] words[5];

  instr_prefetch_queue #(.WORD_SIZE(19), .OPCODE_W(5), .DEPTH(DEPTH)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_opcode  (out_opcode),
    .out_address (out_address),
    .count       (count)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every output against the reference queue.
  task automatic check_model(input string tag);
    logic [18:0] hd;
    int          sz;
    sz = model_q.size();
    hd = (sz != 0) ? model_q[0] : 19'h0;
    check({tag, "_in_ready"},  32'(in_ready),    32'(sz < DEPTH));
    check({tag, "_out_valid"}, 32'(out_valid),   32'(sz != 0));
    check({tag, "_count"},     32'(count),       32'(sz));
    check({tag, "_opcode"},    32'(out_opcode),  32'(hd >> 14));
    check({tag, "_address"},   32'(out_address), 32'(hd & 19'h3FFF));
  endtask

  task automatic drive(input logic r, input logic f, input logic v,
                       input logic [18:0] d, input logic o);
    RST = r; flush = f; in_valid = v; in_instr = d; out_ready = o;
  endtask

  // Advance one edge, updating the model from the pre-edge inputs.
  task automatic cycle(input string tag);
    logic push, pop;
    push = in_valid && (model_q.size() < DEPTH);
    pop  = out_ready && (model_q.size() != 0);
    @(posedge CLK);
    #1;
    if (RST || flush) begin
      model_q.delete();
    end else begin
      if (pop)  void'(model_q.pop_front());
      if (push) model_q.push_back(in_instr);
    end
    check_model(tag);
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 19'h0, 1'b0);
    cycle("reset");
    check("reset_in_ready_const", 32'(in_ready), 32'd1);
    check("reset_opcode_const",   32'(out_opcode), 32'd0);

    // First push right after reset release.
    drive(1'b0, 1'b0, 1'b1, 19'h5802A, 1'b0);
    cycle("push1");
    drive(1'b0, 1'b0, 1'b0, 19'h0, 1'b0);
    check("push1_opcode_const",  32'(out_opcode),  32'h16);
    check("push1_address_const", 32'(out_address), 32'h02A);
    check("push1_count_const",   32'(count),       32'd1);

    // Fill from empty with five back-to-back pushes and no consumer.
    drive(1'b0, 1'b1, 1'b0, 19'h0, 1'b0);
    cycle("flush_a");
    for (int i = 0; i < 5; i++) begin
      words[i] = 19'(32'h1000 * (i + 1) + 32'h11 * i);
      drive(1'b0, 1'b0, 1'b1, words[i], 1'b0);
      cycle("fill");
      if (i == 3) check("fill_in_ready_drop", 32'(in_ready), 32'd0);
    end
    check("fill_count_const", 32'(count), 32'd4);
    check("fill_head_const",  32'({out_opcode, out_address}), 32'(words[0]));

    // Pop and push together while full: push refused, then accepted.
    drive(1'b0, 1'b0, 1'b1, 19'h7ABCD, 1'b1);
    cycle("full_pp");
    check("full_pp_count_const", 32'(count), 32'd3);
    drive(1'b0, 1'b0, 1'b1, 19'h7ABCD, 1'b0);
    cycle("full_retry");
    check("full_retry_count_const", 32'(count), 32'd4);

    // Steady streaming at count=2 through pointer wrap.
    drive(1'b0, 1'b1, 1'b0, 19'h0, 1'b0);
    cycle("flush_b");
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b0, 1'b1, 19'(32'h20000 + i), 1'b0);
      cycle("pre2");
    end
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b0, 1'b1, 19'(32'h30100 + 32'h123 * i), 1'b1);
      cycle("stream");
      check("stream_count_const", 32'(count), 32'd2);
    end

    // Flush beats simultaneous push and pop at count=3.
    drive(1'b0, 1'b0, 1'b1, 19'h11111, 1'b0);
    cycle("pre3");
    check("pre3_count_const", 32'(count), 32'd3);
    drive(1'b0, 1'b1, 1'b1, 19'h4CAFE, 1'b1);
    cycle("flush_c");
    check("flush_c_count_const", 32'(count), 32'd0);
    check("flush_c_valid_const", 32'(out_valid), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 19'h0, 1'b0);
    cycle("flush_c_after");

    // Reset mid-stream with a live handshake at count=2.
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b0, 1'b1, 19'(32'h50000 + i), 1'b0);
      cycle("pre_rst");
    end
    drive(1'b1, 1'b0, 1'b1, 19'h6DEAD, 1'b1);
    cycle("mid_rst");
    check("mid_rst_in_ready_const", 32'(in_ready), 32'd1);
    drive(1'b0, 1'b0, 1'b1, 19'h2BEEF, 1'b0);
    cycle("post_rst");
    check("post_rst_head_const", 32'({out_opcode, out_address}), 32'h2BEEF);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(63) == 0), ($urandom_range(15) == 0),
            1'($urandom), 19'($urandom), 1'($urandom));
      cycle("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_prefetch_queue.md
INSTR_PREFETCH_QUEUE -- requirements
Module: instr_prefetch_queue

Interface
REQ-001 Parameter WORD_SIZE, default 19, instruction word width in bits.
REQ-002 Parameter OPCODE_W, default 5, opcode field width taken from the MSBs of the word.
REQ-003 Parameter DEPTH, default 4, queue entries; power of two, at least 2.
REQ-004 CLK  input  1  single clock; all state updates on its rising edge.
REQ-005 RST  input  1  reset, synchronous and active-high.
REQ-006 flush  input  1  discard all queued instructions (branch/jump redirect).
REQ-007 in_valid  input  1  fetch side presents an instruction.
REQ-008 in_ready  output  1  queue can accept an instruction this cycle.
REQ-009 in_instr  input  WORD_SIZE  fetched instruction word.
REQ-010 out_valid  output  1  head instruction available to the control unit.
REQ-011 out_ready  input  1  control unit consumes the head instruction this cycle.
REQ-012 out_opcode  output  OPCODE_W  head word bits [WORD_SIZE-1 : WORD_SIZE-OPCODE_W].
REQ-013 out_address  output  WORD_SIZE-OPCODE_W  head word bits [WORD_SIZE-OPCODE_W-1 : 0].
REQ-014 count  output  $clog2(DEPTH)+1  number of valid entries.

Function
REQ-015 The block SHALL be a DEPTH-entry FIFO that accepts a push when in_valid && in_ready, and pops when out_valid && out_ready.
REQ-016 in_ready SHALL equal (count < DEPTH); a pop in the same cycle SHALL NOT raise in_ready when the queue is full.
REQ-017 out_valid SHALL equal (count != 0) and SHALL be derived from registered state only.
REQ-018 A push into an empty queue at edge N SHALL make out_valid high after edge N, with no same-cycle bypass.
REQ-019 out_opcode/out_address SHALL be driven from the head entry, and SHALL be all-zero when out_valid is low.
REQ-020 The head fields SHALL hold stable while out_valid && !out_ready.
REQ-021 A simultaneous push and pop on a non-empty, non-full queue SHALL leave count unchanged and preserve FIFO order.
REQ-022 Read and write pointers SHALL wrap modulo DEPTH.
REQ-023 A flush SHALL set count to 0 and both pointers to 0 at the next edge.
REQ-024 During a flush cycle, any push or pop in the same cycle SHALL be ignored; flush has priority over both.
REQ-025 in_ready SHALL remain valid during flush, so the upstream handshake still completes, but the word SHALL be dropped.
REQ-026 Data storage SHALL NOT be cleared by flush or reset; only the pointers and count are cleared.

Reset
REQ-027 With RST high at an edge: count=0, pointers=0, out_valid=0, in_ready=1, out_opcode=0, out_address=0.
REQ-028 RST SHALL take priority over flush, push and pop; an in-flight handshake during reset SHALL be discarded.
REQ-029 The first push SHALL be accepted at the first edge after RST deasserts.

Structure
REQ-030 WORD_SIZE and OPCODE_W defaults, plus an opcode field typedef, SHALL live in the shared constants package.
REQ-031 Storage plus pointers SHALL be one sub-module, ir_fifo_core. The top level SHALL perform the field split and output zeroing.

Verification (DEPTH=4, WORD_SIZE=19, OPCODE_W=5)
REQ-032 Push 19'h5802A into an empty queue -> the next cycle shows out_valid=1, out_opcode=5'h16, out_address=14'h02A, count=1.
REQ-033 Push 5 words back-to-back with out_ready=0 -> in_ready drops after the 4th, the 5th is not accepted, count=4, and the head still shows the 1st word.
REQ-034 Full queue, assert out_ready and in_valid together -> 1st word popped, new word not accepted, count=3; next cycle push accepted, count=4.
REQ-035 count=2, push and pop in the same cycle over 8 cycles -> count stays 2, order preserved through pointer wrap.
REQ-036 count=3 with flush, in_valid and out_ready all high -> next cycle count=0, out_valid=0, out_opcode=0, pushed word absent.
REQ-037 Assert RST mid-stream with count=2 -> next cycle count=0, in_ready=1; push after release appears at the head.
